// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory bus arbiter: FSM encoding, owner codes
// and the supported range of memory read latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not served last.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic winner,
  output logic valid
);

  always_comb begin
    valid  = req0 | req1;
    winner = OWN_CPU;
    if (req0 && req1) begin
      winner = ~rr_last;
    end else if (req1) begin
      winner = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises CPU and DMA accesses onto one memory port, one transaction at a
// time, with round-robin arbitration and registered outputs.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_write,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a master raises req with write/addr/wdata stable; they are
  // latched in the IDLE cycle it wins, and the master sees gnt from ISSUE to
  // ACK and a single-cycle ack. Later changes to req or payload are ignored.

  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam int CNT_W = 3;

  arb_state_t        state;
  logic              owner;
  logic              rr_last;
  logic              cur_write;
  logic [CNT_W-1:0]  lat_cnt;
  logic              win;
  logic              win_valid;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  arb_rr2 u_arb (
    .req0    (cpu_req),
    .req1    (dma_req),
    .rr_last (rr_last),
    .winner  (win),
    .valid   (win_valid)
  );

  always_comb begin
    sel_write = cpu_write;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (win == OWN_DMA) begin
      sel_write = dma_write;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  assign dbg_state = state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      rr_last   <= OWN_DMA;
      cur_write <= 1'b0;
      lat_cnt   <= '0;
      cpu_gnt   <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_gnt   <= 1'b0;
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      mem_write <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_valid) begin
            state     <= ISSUE;
            owner     <= win;
            cur_write <= sel_write;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_write <= sel_write;
            cpu_gnt   <= (win == OWN_CPU);
            dma_gnt   <= (win == OWN_DMA);
            busy      <= 1'b1;
          end else begin
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        ISSUE: begin
          mem_wdata <= '0;
          if (cur_write) begin
            state    <= ACK;
            mem_addr <= '0;
            cpu_ack  <= (owner == OWN_CPU);
            dma_ack  <= (owner == OWN_DMA);
          end else begin
            state   <= WAIT;
            lat_cnt <= CNT_W'(LAT);
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - CNT_W'(1);
          // Address stays on the bus until the last latency cycle, when the
          // memory's data is valid and goes only to the owner's register.
          if (lat_cnt == CNT_W'(1)) begin
            state    <= ACK;
            mem_addr <= '0;
            if (owner == OWN_CPU) begin
              cpu_rdata <= mem_rdata;
              cpu_ack   <= 1'b1;
            end else begin
              dma_rdata <= mem_rdata;
              dma_ack   <= 1'b1;
            end
          end
        end
        ACK: begin
          state   <= IDLE;
          rr_last <= owner;
          cpu_gnt <= 1'b0;
          dma_gnt <= 1'b0;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: one instance with read latency 1 and one with
// read latency 3, each behind a small memory model.
module tb_mem_bus_arbiter;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  int tests = 0;
  int failed = 0;
  logic [9:0] exp_q[$];

  // Instance a: RD_LAT = 1
  logic       a_cpu_req = 0, a_cpu_write = 0, a_dma_req = 0, a_dma_write = 0;
  logic [7:0] a_cpu_addr = 0, a_cpu_wdata = 0, a_dma_addr = 0, a_dma_wdata = 0;
  logic       a_cpu_gnt, a_cpu_ack, a_dma_gnt, a_dma_ack, a_mem_write, a_busy;
  logic [7:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [1:0] a_state;
  logic [7:0] a_mem [256];

  // Instance b: RD_LAT = 3
  logic       b_cpu_req = 0, b_cpu_write = 0, b_dma_req = 0, b_dma_write = 0;
  logic [7:0] b_cpu_addr = 0, b_cpu_wdata = 0, b_dma_addr = 0, b_dma_wdata = 0;
  logic       b_cpu_gnt, b_cpu_ack, b_dma_gnt, b_dma_ack, b_mem_write, b_busy;
  logic [7:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [1:0] b_state;
  logic [7:0] b_mem [256];
  logic [7:0] b_pipe [3];

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut_a (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(a_cpu_req), .cpu_write(a_cpu_write), .cpu_addr(a_cpu_addr),
    .cpu_wdata(a_cpu_wdata), .cpu_gnt(a_cpu_gnt), .cpu_ack(a_cpu_ack),
    .cpu_rdata(a_cpu_rdata),
    .dma_req(a_dma_req), .dma_write(a_dma_write), .dma_addr(a_dma_addr),
    .dma_wdata(a_dma_wdata), .dma_gnt(a_dma_gnt), .dma_ack(a_dma_ack),
    .dma_rdata(a_dma_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_write(a_mem_write),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .dbg_state(a_state)
  );

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u_dut_b (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(b_cpu_req), .cpu_write(b_cpu_write), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_gnt(b_cpu_gnt), .cpu_ack(b_cpu_ack),
    .cpu_rdata(b_cpu_rdata),
    .dma_req(b_dma_req), .dma_write(b_dma_write), .dma_addr(b_dma_addr),
    .dma_wdata(b_dma_wdata), .dma_gnt(b_dma_gnt), .dma_ack(b_dma_ack),
    .dma_rdata(b_dma_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_write(b_mem_write),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .dbg_state(b_state)
  );

  // Memory models: preload while reset is high, data valid RD_LAT cycles after address.
  always @(posedge Clk) begin
    if (Reset) a_mem[8'h10] <= 8'hA5;
    else if (a_mem_write) a_mem[a_mem_addr] <= a_mem_wdata;
    a_mem_rdata <= a_mem[a_mem_addr];
  end

  always @(posedge Clk) begin
    if (Reset) begin
      b_mem[8'h05] <= 8'hC3;
      b_mem[8'h06] <= 8'h96;
    end else if (b_mem_write) begin
      b_mem[b_mem_addr] <= b_mem_wdata;
    end
    b_pipe[0] <= b_mem[b_mem_addr];
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_mem_rdata = b_pipe[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_ack(input logic inst, input logic port, input logic [7:0] rdata);
    logic [9:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL unexpected_ack: got inst=%0d port=%0d rdata=%0h expected no ack", inst, port, rdata);
    end else begin
      e = exp_q.pop_front();
      if (e !== {inst, port, rdata}) begin
        failed++;
        $display("FAIL ack_scoreboard: got %0h expected %0h (t=%0t)", {inst, port, rdata}, e, $time);
      end
    end
  endtask

  // Monitor: pops one expectation per ack pulse and watches grant exclusivity.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (a_cpu_ack) mon_ack(1'b0, 1'b0, a_cpu_rdata);
      if (a_dma_ack) mon_ack(1'b0, 1'b1, a_dma_rdata);
      if (b_cpu_ack) mon_ack(1'b1, 1'b0, b_cpu_rdata);
      if (b_dma_ack) mon_ack(1'b1, 1'b1, b_dma_rdata);
      if (a_cpu_gnt || a_dma_gnt) check("gnt_exclusive_a", a_cpu_gnt & a_dma_gnt, 0);
      if (b_cpu_gnt || b_dma_gnt) check("gnt_exclusive_b", b_cpu_gnt & b_dma_gnt, 0);
    end
  end

  task automatic next();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    next();
    next();
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge Clk);
    check("rst_outputs_a", {a_cpu_gnt, a_cpu_ack, a_dma_gnt, a_dma_ack, a_mem_write, a_busy,
                            a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata}, 0);
    check("rst_outputs_b", {b_cpu_gnt, b_cpu_ack, b_dma_gnt, b_dma_ack, b_mem_write, b_busy,
                            b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata}, 0);
    check("rst_state", a_state, 0);
    next();

    // 1: CPU read of 0x10 (0xA5), latency 1
    a_cpu_write = 0; a_cpu_addr = 8'h10; a_cpu_req = 1;
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      check("t1_cpu_gnt", a_cpu_gnt, (k >= 1 && k <= 3));
      check("t1_cpu_ack", a_cpu_ack, (k == 3));
      check("t1_dma_quiet", {a_dma_gnt, a_dma_ack, a_dma_rdata}, 0);
      if (k == 3) check("t1_cpu_rdata", a_cpu_rdata, 8'hA5);
      if (a_cpu_ack) a_cpu_req = 0;
      next();
    end

    // 2: DMA write 0x3C to 0x80
    a_dma_write = 1; a_dma_addr = 8'h80; a_dma_wdata = 8'h3C; a_dma_req = 1;
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      check("t2_mem_write", a_mem_write, (k == 1));
      if (k == 1) begin
        check("t2_mem_addr", a_mem_addr, 8'h80);
        check("t2_mem_wdata", a_mem_wdata, 8'h3C);
      end
      check("t2_dma_ack", a_dma_ack, (k == 2));
      check("t2_busy", a_busy, (k == 1 || k == 2));
      if (a_dma_ack) a_dma_req = 0;
      next();
    end
    check("t2_mem_model", a_mem[8'h80], 8'h3C);

    // 3: simultaneous requests held through three transactions
    do_reset();
    a_cpu_write = 0; a_cpu_addr = 8'h10; a_cpu_req = 1;
    a_dma_write = 0; a_dma_addr = 8'h80; a_dma_req = 1;
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    exp_q.push_back({1'b0, 1'b1, 8'h3C});
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    for (int k = 0; k < 13; k++) begin
      @(negedge Clk);
      check("t3_cpu_gnt", a_cpu_gnt, ((k >= 1 && k <= 3) || (k >= 9 && k <= 11)));
      check("t3_dma_gnt", a_dma_gnt, (k >= 5 && k <= 7));
      check("t3_cpu_ack", a_cpu_ack, (k == 3 || k == 11));
      check("t3_dma_ack", a_dma_ack, (k == 7));
      if (k == 11) begin
        a_cpu_req = 0;
        a_dma_req = 0;
      end
      next();
    end

    // 4: latency-3 CPU read of 0x05, DMA read of 0x06 requested in cycle 2
    b_cpu_write = 0; b_cpu_addr = 8'h05; b_cpu_req = 1;
    b_dma_write = 0; b_dma_addr = 8'h06;
    exp_q.push_back({1'b1, 1'b0, 8'hC3});
    exp_q.push_back({1'b1, 1'b1, 8'h96});
    for (int k = 0; k < 13; k++) begin
      if (k == 2) b_dma_req = 1;
      @(negedge Clk);
      check("t4_mem_addr", b_mem_addr, (k >= 1 && k <= 4) ? 8'h05 :
                                       (k >= 7 && k <= 10) ? 8'h06 : 8'h00);
      check("t4_cpu_gnt", b_cpu_gnt, (k >= 1 && k <= 5));
      check("t4_cpu_ack", b_cpu_ack, (k == 5));
      check("t4_dma_gnt", b_dma_gnt, (k >= 7 && k <= 11));
      check("t4_dma_ack", b_dma_ack, (k == 11));
      if (b_cpu_ack) b_cpu_req = 0;
      if (b_dma_ack) b_dma_req = 0;
      next();
    end

    // 5: reset during WAIT of a DMA read, then a tie goes to the CPU
    a_dma_write = 0; a_dma_addr = 8'h80; a_dma_req = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check("t5_dma_gnt", a_dma_gnt, (k >= 1));
      if (k == 2) check("t5_state_wait", a_state, 2);
      if (k < 2) next();
    end
    Reset = 1;
    a_dma_req = 0;
    next();
    @(negedge Clk);
    check("t5_after_reset", {a_cpu_gnt, a_cpu_ack, a_dma_gnt, a_dma_ack, a_mem_write, a_busy,
                             a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata}, 0);
    check("t5_state_idle", a_state, 0);
    next();
    Reset = 0;
    a_cpu_write = 0; a_cpu_addr = 8'h10; a_cpu_req = 1;
    a_dma_write = 1; a_dma_addr = 8'h31; a_dma_wdata = 8'h22; a_dma_req = 1;
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    for (int k = 0; k < 7; k++) begin
      @(negedge Clk);
      check("t5_cpu_gnt", a_cpu_gnt, (k >= 1 && k <= 3));
      check("t5_dma_gnt", a_dma_gnt, (k >= 5 && k <= 6));
      check("t5_cpu_ack", a_cpu_ack, (k == 3));
      check("t5_dma_ack", a_dma_ack, (k == 6));
      if (a_cpu_ack) a_cpu_req = 0;
      if (a_dma_ack) a_dma_req = 0;
      next();
    end

    // 6: CPU write 0x77 to 0x20, request dropped during ISSUE
    a_cpu_write = 1; a_cpu_addr = 8'h20; a_cpu_wdata = 8'h77; a_cpu_req = 1;
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      if (k == 1) a_cpu_req = 0;
      check("t6_mem_write", a_mem_write, (k == 1));
      if (k == 1) begin
        check("t6_mem_addr", a_mem_addr, 8'h20);
        check("t6_mem_wdata", a_mem_wdata, 8'h77);
      end
      check("t6_cpu_ack", a_cpu_ack, (k == 2));
      check("t6_cpu_rdata", a_cpu_rdata, 8'hA5);
      next();
    end
    check("t6_mem_model", a_mem[8'h20], 8'h77);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
